// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side is the master and the controller side is the slave.
interface hazard_stall_controller_if;
  logic [4:0] rs1_address_id_i;
  logic [4:0] rs2_address_id_i;
  logic       rs1_used_id_i;
  logic       rs2_used_id_i;
  logic       branch_id_i;
  logic       branch_taken_i;
  logic       rd_we_ex_i;
  logic [4:0] rd_address_ex_i;
  logic       mem_to_reg_ex_i;
  logic       div_ex_i;
  logic [4:0] rd_address_mem_i;
  logic       mem_to_reg_mem_i;

  logic       pc_en_o;
  logic       if_id_en_o;
  logic       if_id_flush_o;
  logic       id_ex_en_o;
  logic       id_ex_flush_o;
  logic       ex_mem_flush_o;
  logic       div_start_o;
  logic       div_result_valid_o;
  logic       div_busy_o;

  modport master (
    output rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
           branch_id_i, branch_taken_i, rd_we_ex_i, rd_address_ex_i,
           mem_to_reg_ex_i, div_ex_i, rd_address_mem_i, mem_to_reg_mem_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_flush_o, div_start_o, div_result_valid_o, div_busy_o
  );

  modport slave (
    input  rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
           branch_id_i, branch_taken_i, rd_we_ex_i, rd_address_ex_i,
           mem_to_reg_ex_i, div_ex_i, rd_address_mem_i, mem_to_reg_mem_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_flush_o, div_start_o, div_result_valid_o, div_busy_o
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard controller for the 5-stage core: load-use and ID-branch operand stalls,
// taken-branch IF/ID flush, and sequencing of the multi-cycle divider in EX.
module hazard_stall_controller #(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_stall_controller_if.slave  hif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] DIV_WAIT = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic active;
  logic match_ex;
  logic match_mem;
  logic load_use;
  logic br_haz;
  logic id_stall;
  logic div_stall;
  logic start_div;

  // While reset is high every hazard input is treated as 0, so the
  // pipeline sees plain RUN behaviour regardless of the stored state.
  assign active = ~reset;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // can leave it unassigned and infer a latch.
    match_ex  = 1'b0;
    match_mem = 1'b0;
    if (hif.rd_we_ex_i && hif.rd_address_ex_i != 5'd0) begin
      match_ex = (hif.rs1_used_id_i && hif.rs1_address_id_i == hif.rd_address_ex_i) ||
                 (hif.rs2_used_id_i && hif.rs2_address_id_i == hif.rd_address_ex_i);
    end
    if (hif.rd_address_mem_i != 5'd0) begin
      match_mem = (hif.rs1_used_id_i && hif.rs1_address_id_i == hif.rd_address_mem_i) ||
                  (hif.rs2_used_id_i && hif.rs2_address_id_i == hif.rd_address_mem_i);
    end
    match_ex  = match_ex & active;
    match_mem = match_mem & active;
  end

  assign load_use  = hif.mem_to_reg_ex_i & match_ex;
  assign br_haz    = hif.branch_id_i & (match_ex | (hif.mem_to_reg_mem_i & match_mem));
  assign id_stall  = load_use | br_haz;

  assign start_div = active & (state == RUN) & hif.div_ex_i;
  assign div_stall = start_div | (active & (state == DIV_WAIT));

  // A stalled divide holds EX and bubbles MEM; an ID stall lets EX advance
  // and bubbles EX instead. The divider stall wins when both apply.
  always_comb begin
    hif.pc_en_o        = 1'b1;
    hif.if_id_en_o     = 1'b1;
    hif.id_ex_en_o     = 1'b1;
    hif.id_ex_flush_o  = 1'b0;
    hif.ex_mem_flush_o = 1'b0;
    if (div_stall) begin
      hif.pc_en_o        = 1'b0;
      hif.if_id_en_o     = 1'b0;
      hif.id_ex_en_o     = 1'b0;
      hif.ex_mem_flush_o = 1'b1;
    end else if (id_stall) begin
      hif.pc_en_o       = 1'b0;
      hif.if_id_en_o    = 1'b0;
      hif.id_ex_flush_o = 1'b1;
    end
  end

  // A branch is only resolved once its operands are current.
  assign hif.if_id_flush_o      = active & hif.branch_taken_i & hif.branch_id_i &
                                  ~id_stall & ~div_stall;
  assign hif.div_start_o        = start_div;
  assign hif.div_result_valid_o = active & (state == DIV_DONE);
  assign hif.div_busy_o         = div_stall;

  // DIV_DONE always returns to RUN, so a divide still sitting in EX that
  // cycle cannot restart; the next divide is started from RUN.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hif.div_ex_i) begin
            state <= DIV_WAIT;
            cnt   <= '0;
          end
        end
        DIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DIV_DONE;
        end
        DIV_DONE: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed test-plan scenarios
// followed by randomized traffic compared against a cycle-level reference model.
module tb_hazard_stall_controller;

  localparam int L = 4;

  // Output vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  // ex_mem_flush, div_start, div_result_valid, div_busy.
  localparam logic [8:0] V_IDLE      = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] V_ID_STALL  = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] V_DIV_START = 9'b0_0_0_0_0_1_1_0_1;
  localparam logic [8:0] V_DIV_BUSY  = 9'b0_0_0_0_0_1_0_0_1;
  localparam logic [8:0] V_DIV_VALID = 9'b1_1_0_1_0_0_0_1_0;
  localparam logic [8:0] V_TAKEN     = 9'b1_1_1_1_0_0_0_0_0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_controller_if hif ();

  hazard_stall_controller #(.DIV_LATENCY(L), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {hif.pc_en_o, hif.if_id_en_o, hif.if_id_flush_o, hif.id_ex_en_o,
                hif.id_ex_flush_o, hif.ex_mem_flush_o, hif.div_start_o,
                hif.div_result_valid_o, hif.div_busy_o};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic br, input logic tk);
    hif.rs1_address_id_i = rs1;
    hif.rs2_address_id_i = rs2;
    hif.rs1_used_id_i    = u1;
    hif.rs2_used_id_i    = u2;
    hif.branch_id_i      = br;
    hif.branch_taken_i   = tk;
  endtask

  task automatic set_ex(input logic we, input logic [4:0] rd, input logic ld, input logic dv);
    hif.rd_we_ex_i      = we;
    hif.rd_address_ex_i = rd;
    hif.mem_to_reg_ex_i = ld;
    hif.div_ex_i        = dv;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic ld);
    hif.rd_address_mem_i = rd;
    hif.mem_to_reg_mem_i = ld;
  endtask

  task automatic clear_inputs();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b0, 5'd0, 1'b0, 1'b0);
    set_mem(5'd0, 1'b0);
  endtask

  // ---------------- reference model ----------------
  int m_wait_left = 0;  // divider wait cycles still to go
  bit m_done      = 0;  // result is valid this cycle

  function automatic bit id_reads(input logic [4:0] r);
    return (r != 5'd0) &&
           ((hif.rs1_used_id_i && hif.rs1_address_id_i == r) ||
            (hif.rs2_used_id_i && hif.rs2_address_id_i == r));
  endfunction

  function automatic logic [8:0] model_out();
    bit ex_dep, mem_dep, need_id_stall, div_idle, start, hold;
    if (reset) return V_IDLE;
    ex_dep        = hif.rd_we_ex_i && id_reads(hif.rd_address_ex_i);
    mem_dep       = id_reads(hif.rd_address_mem_i);
    need_id_stall = (hif.mem_to_reg_ex_i && ex_dep) ||
                    (hif.branch_id_i && (ex_dep || (hif.mem_to_reg_mem_i && mem_dep)));
    div_idle      = (m_wait_left == 0) && !m_done;
    start         = div_idle && hif.div_ex_i;
    hold          = start || (m_wait_left > 0);
    if (hold) return {6'b000001, start, 1'b0, 1'b1};
    if (need_id_stall) return {8'b00011000, 1'b0} | {7'b0, m_done, 1'b0};
    return {3'b110, 6'b100000} | {2'b0, hif.branch_id_i && hif.branch_taken_i, 6'b0}
           | {7'b0, m_done, 1'b0};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_wait_left = 0;
      m_done      = 0;
    end else if (m_wait_left == 0 && !m_done && hif.div_ex_i) begin
      m_wait_left = L;
    end else if (m_wait_left > 0) begin
      m_wait_left = m_wait_left - 1;
      m_done      = (m_wait_left == 0);
    end else begin
      m_done = 0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    set_ex(1'b1, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    set_id(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ex(1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_ID_STALL) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected %b", obs, V_ID_STALL);
    end
    next_cycle();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0);
    set_mem(5'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL load_use_single_cycle: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    clear_inputs();
    set_id(5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ex(1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL load_use_x0: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch_dep();
    set_id(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    set_ex(1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_ID_STALL) begin
      errors++;
      $display("FAIL branch_ex_dep: got %b expected %b", obs, V_ID_STALL);
    end
    next_cycle();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0);
    set_mem(5'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL branch_mem_nonload: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    set_mem(5'd7, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_ID_STALL) begin
      errors++;
      $display("FAIL branch_mem_load: got %b expected %b", obs, V_ID_STALL);
    end
    next_cycle();
    set_mem(5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL branch_mem_load_release: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_taken_branch();
    set_id(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_TAKEN) begin
      errors++;
      $display("FAIL taken_branch_flush: got %b expected %b", obs, V_TAKEN);
    end
    next_cycle();
    set_ex(1'b1, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_ID_STALL) begin
      errors++;
      $display("FAIL taken_branch_stalled: got %b expected %b", obs, V_ID_STALL);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_divide();
    int stalls = 0;
    set_ex(1'b1, 5'd9, 1'b0, 1'b1);
    for (int c = 0; c <= L + 1; c++) begin
      logic [8:0] exp;
      exp = (c == 0) ? V_DIV_START : (c <= L) ? V_DIV_BUSY : V_DIV_VALID;
      @(negedge clk);
      if (hif.div_busy_o === 1'b1) stalls++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL divide_cycle_%0d: got %b expected %b", c, obs, exp);
      end
      next_cycle();
    end
    checks++;
    if (stalls != L + 1) begin
      errors++;
      $display("FAIL divide_stall_length: got %0d expected %0d", stalls, L + 1);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL divide_no_restart: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_div();
    set_ex(1'b1, 5'd9, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_mid_div_outputs: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== V_DIV_START) begin
      errors++;
      $display("FAIL reset_mid_div_restart: got %b expected %b", obs, V_DIV_START);
    end
    next_cycle();
    set_ex(1'b1, 5'd9, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_mid_div_idle: got %b expected %b", obs, V_IDLE);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int starts = 0;
    int stalls = 0;
    int valids = 0;
    set_ex(1'b1, 5'd9, 1'b0, 1'b1);
    for (int c = 0; c < 2 * (L + 2); c++) begin
      @(negedge clk);
      if (hif.div_start_o === 1'b1) starts++;
      if (hif.div_busy_o === 1'b1) stalls++;
      if (hif.div_result_valid_o === 1'b1) valids++;
      if (c == L + 2) begin
        checks++;
        if (obs !== V_DIV_START) begin
          errors++;
          $display("FAIL back_to_back_second_start: got %b expected %b", obs, V_DIV_START);
        end
      end
      next_cycle();
    end
    clear_inputs();
    checks++;
    if (starts != 2 || stalls != 2 * (L + 1) || valids != 2) begin
      errors++;
      $display("FAIL back_to_back_counts: got starts=%0d stalls=%0d valids=%0d expected 2 %0d 2",
               starts, stalls, valids, 2 * (L + 1));
    end
    next_cycle();
  endtask

  task automatic test_random();
    reset = 1'b1;
    clear_inputs();
    model_step();
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [8:0] exp;
      reset = ($urandom_range(0, 49) == 0);
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      set_ex(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 5) == 0));
      set_mem(5'($urandom_range(0, 3)), 1'($urandom));
      @(negedge clk);
      exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b expected %b", c, obs, exp);
      end
      model_step();
      next_cycle();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    test_reset();
    test_load_use();
    test_branch_dep();
    test_taken_branch();
    test_divide();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage RV32IM_Zbb core; sits alongside the forwarding logic.
- Detects hazards that forwarding cannot resolve (load-use, ID-stage branch operand dependencies) and sequences the multi-cycle divider (DIV/DIVU/REM/REMU) in EX.
- Drives the pipeline-register enables, bubble inserts and the IF/ID flush.

Parameters:
- DIV_LATENCY, 32, divider cycles from the start pulse to a valid result; legal range 2..255.
- CNT_W, 8, divider cycle counter width; must hold DIV_LATENCY-1.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- rs1_address_id_i  input  5  rs1 of the instruction in ID
- rs2_address_id_i  input  5  rs2 of the instruction in ID
- rs1_used_id_i  input  1  ID instruction reads rs1
- rs2_used_id_i  input  1  ID instruction reads rs2
- branch_id_i  input  1  ID instruction is a conditional branch (compared in ID)
- branch_taken_i  input  1  ID branch comparator result: taken
- rd_we_ex_i  input  1  EX instruction writes rd
- rd_address_ex_i  input  5  rd of the EX instruction
- mem_to_reg_ex_i  input  1  EX instruction is a load
- div_ex_i  input  1  EX instruction is DIV/DIVU/REM/REMU
- rd_address_mem_i  input  5  rd of the MEM instruction
- mem_to_reg_mem_i  input  1  MEM instruction is a load
- pc_en_o  output  1  PC register enable
- if_id_en_o  output  1  IF/ID register enable
- if_id_flush_o  output  1  clear IF/ID (taken branch)
- id_ex_en_o  output  1  ID/EX register enable
- id_ex_flush_o  output  1  load bubble into ID/EX
- ex_mem_flush_o  output  1  load bubble into EX/MEM
- div_start_o  output  1  one-cycle divider start pulse
- div_result_valid_o  output  1  divider result valid; EX result mux selects divider
- div_busy_o  output  1  divider sequence in progress

Behaviour:
- FSM states: RUN, DIV_WAIT, DIV_DONE. Counter cnt is CNT_W bits wide.
- Reset: state=RUN, cnt=0. While reset is high, all outputs are driven to their RUN values with every hazard input treated as 0: enables=1, flushes=0, div_start_o=0, div_result_valid_o=0, div_busy_o=0.
- Reset asserted mid-division aborts the sequence; the next cycle is in RUN.
- Register x0 never creates a hazard. Every rd comparison also requires rd != 0.
- Hazard terms:
  - match_ex = rd_we_ex_i & rd_ex!=0 & ((rs1_used_id_i & rs1_id==rd_ex) | (rs2_used_id_i & rs2_id==rd_ex))
  - match_mem = rd_mem!=0 & ((rs1_used_id_i & rs1_id==rd_mem) | (rs2_used_id_i & rs2_id==rd_mem))
  - load_use = mem_to_reg_ex_i & match_ex
  - br_haz = branch_id_i & (match_ex | (mem_to_reg_mem_i & match_mem))
  - id_stall = load_use | br_haz
- Divider stall: div_stall = (state==RUN & div_ex_i) | state==DIV_WAIT.
- Output priority: div_stall takes precedence over id_stall.
  - div_stall: pc_en_o=0, if_id_en_o=0, id_ex_en_o=0, id_ex_flush_o=0, ex_mem_flush_o=1 (EX is held, a bubble goes to MEM).
  - else id_stall: pc_en_o=0, if_id_en_o=0, id_ex_en_o=1, id_ex_flush_o=1, ex_mem_flush_o=0 (EX advances, a bubble enters EX).
  - else: all enables=1, all flushes=0.
- if_id_flush_o = branch_taken_i & branch_id_i & ~id_stall & ~div_stall. A branch is never resolved while its operands are stale.
- Divider FSM transitions:
  - RUN: if div_ex_i, assert div_start_o (combinational, this cycle only), go to DIV_WAIT, cnt<=0.
  - DIV_WAIT: cnt<=cnt+1. When cnt==DIV_LATENCY-1, go to DIV_DONE.
  - DIV_DONE: div_result_valid_o=1 and no divider stall. The division advances to MEM this cycle. Go to RUN unconditionally; div_ex_i is ignored in DIV_DONE.
  - Back-to-back divides: the second divide enters EX in the cycle after DIV_DONE and is started from RUN.
- Stall length: a divide costs exactly DIV_LATENCY+1 stall cycles (start cycle plus DIV_LATENCY wait cycles).
- div_busy_o = div_stall.
- id_stall may coincide with DIV_DONE. The ID stall applies while EX still advances, so the divide leaves EX and no restart occurs.
- All outputs are combinational from state, cnt and inputs. No output is registered except the state and counter.

Test Plan:
- Load-use: lw x5 in EX (mem_to_reg_ex_i=1, rd_we_ex_i=1, rd_ex=5); add x6,x5,x1 in ID with rs1_used=1 -> exactly 1 cycle of pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Same case with rd_ex=0 -> no stall.
- Branch dependency: beq x7,x2 in ID, EX writes x7 (non-load) -> 1 stall cycle. Repeat with MEM holding a load of x7 -> 1 stall cycle. With MEM holding a non-load writing x7 -> no stall.
- Divide with DIV_LATENCY=4, div_ex_i=1 at cycle 0:
  - div_start_o=1 only in cycle 0.
  - div_busy_o=1 and ex_mem_flush_o=1 in cycles 0..4.
  - div_result_valid_o=1 in cycle 5, with all enables=1 and no restart.
- Taken branch: branch_id_i=1, branch_taken_i=1, no hazard -> if_id_flush_o=1 for that cycle. Same with a simultaneous load-use hazard -> if_id_flush_o=0 and the stall is asserted.
- Reset at cycle 2 of a DIV_LATENCY=4 divide -> next cycle in RUN: div_busy_o=0, enables=1. With div_ex_i held at 1 after reset, div_start_o fires again on the first post-reset cycle.
- Back-to-back divides: second div_ex_i in the cycle after DIV_DONE -> a new start pulse and a full DIV_LATENCY+1 stall.
